// File: rtl/cksum_sched.sv
// Checksum job sequencer: walks a small job table once per packet and drives
// the checksum engine start/field handshake. Optional watchdog: CKSUM_SCHED_TIMEOUT_EN.
module cksum_sched #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int N_JOBS  = 4,
  parameter int TIMEOUT = 1024,
  localparam int IDX_W  = (N_JOBS > 1) ? $clog2(N_JOBS) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cfg_we_i,
  input  logic [IDX_W-1:0]  cfg_idx_i,
  input  logic              cfg_valid_i,
  input  logic [ADDR_W-1:0] cfg_src_off_i,
  input  logic [DATA_W-1:0] cfg_len_i,
  input  logic [ADDR_W-1:0] cfg_dst_off_i,
  input  logic              pkt_start_i,
  input  logic [ADDR_W-1:0] pkt_base_i,
  output logic              start_o,
  output logic [ADDR_W-1:0] field_start_o,
  output logic [DATA_W-1:0] field_len_o,
  output logic [ADDR_W-1:0] dst_field_start_o,
  input  logic              cksum_ready_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              err_o
);

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] SCAN    = 3'd1;
  localparam logic [2:0] ISSUE   = 3'd2;
  localparam logic [2:0] WAIT    = 3'd3;
  localparam logic [2:0] RELEASE = 3'd4;
  localparam logic [2:0] FIN     = 3'd5;

  localparam logic [IDX_W:0] END_IDX = (IDX_W + 1)'(N_JOBS);

  logic [2:0]        state;
  logic [IDX_W:0]    idx;
  logic [ADDR_W-1:0] base;
  logic              wait_expired;

  logic              job_valid [N_JOBS];
  logic [ADDR_W-1:0] job_src   [N_JOBS];
  logic [DATA_W-1:0] job_len   [N_JOBS];
  logic [ADDR_W-1:0] job_dst   [N_JOBS];

  // Degenerate configurations are not supported; this block marks them in the
  // elaborated hierarchy.
  if (N_JOBS < 1 || TIMEOUT < 2) begin : g_unsupported_cfg
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state             <= IDLE;
      idx               <= '0;
      base              <= '0;
      start_o           <= 1'b0;
      field_start_o     <= '0;
      field_len_o       <= '0;
      dst_field_start_o <= '0;
      busy_o            <= 1'b0;
      done_o            <= 1'b0;
      // NOTE: the job table is small and must come out of reset invalid, so it
      // is reset like ordinary state rather than inferred as a RAM.
      for (int i = 0; i < N_JOBS; i++) begin
        job_valid[i] <= 1'b0;
        job_src[i]   <= '0;
        job_len[i]   <= '0;
        job_dst[i]   <= '0;
      end
    end else begin
      done_o <= 1'b0;

      // busy_o is still 0 in IDLE, so a write alongside pkt_start lands before
      // the first SCAN reads the table.
      if (cfg_we_i && !busy_o) begin
        job_valid[cfg_idx_i] <= cfg_valid_i;
        job_src[cfg_idx_i]   <= cfg_src_off_i;
        job_len[cfg_idx_i]   <= cfg_len_i;
        job_dst[cfg_idx_i]   <= cfg_dst_off_i;
      end

      case (state)
        IDLE: begin
          if (pkt_start_i) begin
            base   <= pkt_base_i;
            idx    <= '0;
            busy_o <= 1'b1;
            state  <= SCAN;
          end
        end
        SCAN: begin
          if (idx == END_IDX) begin
            state <= FIN;
          end else if (job_valid[idx[IDX_W-1:0]]) begin
            field_start_o     <= base + job_src[idx[IDX_W-1:0]];
            field_len_o       <= job_len[idx[IDX_W-1:0]];
            dst_field_start_o <= base + job_dst[idx[IDX_W-1:0]];
            start_o           <= 1'b1;
            state             <= ISSUE;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        // The engine's ready is still high from the previous job here.
        ISSUE: state <= WAIT;
        WAIT: begin
          if (cksum_ready_i || wait_expired) begin
            start_o <= 1'b0;
            state   <= RELEASE;
          end
        end
        RELEASE: begin
          idx   <= idx + 1'b1;
          state <= SCAN;
        end
        FIN: begin
          done_o <= 1'b1;
          busy_o <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef CKSUM_SCHED_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  logic [CNT_W-1:0] wait_cnt;

  assign wait_expired = (wait_cnt == CNT_W'(TIMEOUT - 1));

  // Counter is held at zero outside WAIT, so it is clear on every ISSUE.
  always_ff @(posedge clk) begin
    if (rst) begin
      wait_cnt <= '0;
      err_o    <= 1'b0;
    end else begin
      if (state == WAIT) wait_cnt <= wait_cnt + 1'b1;
      else               wait_cnt <= '0;
      if (state == WAIT && !cksum_ready_i && wait_expired) err_o <= 1'b1;
    end
  end
`else
  assign wait_expired = 1'b0;
  assign err_o        = 1'b0;
`endif

endmodule

// File: tb/tb_cksum_sched.sv
// Directed bench for cksum_sched: hand-computed field addresses, latencies and
// handshake ordering, with a simple engine model driven from the stimulus.
module tb_cksum_sched;

  logic        clk = 1'b0;
  logic        rst;
  logic        cfg_we_i;
  logic [1:0]  cfg_idx_i;
  logic        cfg_valid_i;
  logic [31:0] cfg_src_off_i;
  logic [31:0] cfg_len_i;
  logic [31:0] cfg_dst_off_i;
  logic        pkt_start_i;
  logic [31:0] pkt_base_i;
  logic        start_o;
  logic [31:0] field_start_o;
  logic [31:0] field_len_o;
  logic [31:0] dst_field_start_o;
  logic        cksum_ready_i;
  logic        busy_o;
  logic        done_o;
  logic        err_o;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  cksum_sched #(.ADDR_W(32), .DATA_W(32), .N_JOBS(4), .TIMEOUT(16)) dut (
    .clk               (clk),
    .rst               (rst),
    .cfg_we_i          (cfg_we_i),
    .cfg_idx_i         (cfg_idx_i),
    .cfg_valid_i       (cfg_valid_i),
    .cfg_src_off_i     (cfg_src_off_i),
    .cfg_len_i         (cfg_len_i),
    .cfg_dst_off_i     (cfg_dst_off_i),
    .pkt_start_i       (pkt_start_i),
    .pkt_base_i        (pkt_base_i),
    .start_o           (start_o),
    .field_start_o     (field_start_o),
    .field_len_o       (field_len_o),
    .dst_field_start_o (dst_field_start_o),
    .cksum_ready_i     (cksum_ready_i),
    .busy_o            (busy_o),
    .done_o            (done_o),
    .err_o             (err_o)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; outputs are sampled and inputs driven 1 time unit later.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_cfg(input logic [1:0] idx, input logic valid, input logic [31:0] src,
                         input logic [31:0] len, input logic [31:0] dst);
    cfg_we_i      = 1'b1;
    cfg_idx_i     = idx;
    cfg_valid_i   = valid;
    cfg_src_off_i = src;
    cfg_len_i     = len;
    cfg_dst_off_i = dst;
  endtask

  task automatic write_job(input logic [1:0] idx, input logic valid, input logic [31:0] src,
                           input logic [31:0] len, input logic [31:0] dst);
    set_cfg(idx, valid, src, len, dst);
    cyc();
    cfg_we_i = 1'b0;
  endtask

  task automatic start_pkt(input logic [31:0] base);
    pkt_start_i = 1'b1;
    pkt_base_i  = base;
    cyc();
    pkt_start_i = 1'b0;
  endtask

  // Engine model for one job: wait for start, keep ready stale-high for the
  // ISSUE cycle, drop it while computing, then raise it and expect start to fall.
  task automatic serve(input string tag, input int compute, input logic [31:0] ef,
                       input logic [31:0] el, input logic [31:0] ed, input bit inject);
    int n = 0;
    bit low_seen = 1'b0;
    while (start_o !== 1'b1 && n < 30) begin
      if (start_o === 1'b0 && cksum_ready_i) low_seen = 1'b1;
      cyc();
      n++;
    end
    check({tag, " start rise"}, start_o, 1'b1);
    if (start_o !== 1'b1) return;
    check({tag, " low gap before start"}, low_seen, 1'b1);
    check({tag, " field_start"}, field_start_o, ef);
    check({tag, " field_len"}, field_len_o, el);
    check({tag, " dst_field_start"}, dst_field_start_o, ed);
    cyc();
    check({tag, " start held in ISSUE"}, start_o, 1'b1);
    cksum_ready_i = 1'b0;
    for (int k = 0; k < compute; k++) begin
      if (inject && k == 0) begin
        pkt_start_i = 1'b1;
        pkt_base_i  = 32'h9000;
        set_cfg(2'd0, 1'b1, 32'h55, 32'd99, 32'h66);
      end
      cyc();
      pkt_start_i = 1'b0;
      cfg_we_i    = 1'b0;
    end
    check({tag, " start held in WAIT"}, start_o, 1'b1);
    check({tag, " field stable in WAIT"}, field_start_o, ef);
    cksum_ready_i = 1'b1;
    cyc();
    check({tag, " start fall"}, start_o, 1'b0);
  endtask

  // Wait for done_o; optionally check its latency; then insist on no second pulse.
  task automatic finish_pkt(input string tag, input int exp_n);
    int n = 0;
    int extra = 0;
    bit saw_start = 1'b0;
    while (done_o !== 1'b1 && n < 40) begin
      cyc();
      n++;
      if (start_o === 1'b1) saw_start = 1'b1;
    end
    check({tag, " done pulse"}, done_o, 1'b1);
    if (exp_n > 0) check({tag, " done latency"}, n, exp_n);
    check({tag, " busy low at done"}, busy_o, 1'b0);
    check({tag, " no stray start"}, saw_start, 1'b0);
    for (int k = 0; k < 8; k++) begin
      cyc();
      if (done_o === 1'b1 || busy_o === 1'b1) extra++;
    end
    check({tag, " single done, idle after"}, extra, 0);
  endtask

  initial begin
    rst           = 1'b1;
    cfg_we_i      = 1'b0;
    cfg_idx_i     = '0;
    cfg_valid_i   = 1'b0;
    cfg_src_off_i = '0;
    cfg_len_i     = '0;
    cfg_dst_off_i = '0;
    pkt_start_i   = 1'b0;
    pkt_base_i    = '0;
    cksum_ready_i = 1'b1;
    cyc();
    cyc();
    check("reset start_o", start_o, 1'b0);
    check("reset busy_o", busy_o, 1'b0);
    check("reset done_o", done_o, 1'b0);
    check("reset err_o", err_o, 1'b0);
    check("reset field_start_o", field_start_o, 32'h0);
    check("reset field_len_o", field_len_o, 32'h0);
    check("reset dst_field_start_o", dst_field_start_o, 32'h0);
    rst = 1'b0;
    cyc();

    // Empty table: SCAN x5 (idx 0..4), FIN, done on the 6th edge after pkt_start.
    start_pkt(32'h100);
    check("empty busy", busy_o, 1'b1);
    finish_pkt("empty", 6);

    // Single job at base 0x100.
    write_job(2'd0, 1'b1, 32'h0E, 32'd20, 32'h18);
    start_pkt(32'h100);
    serve("single", 3, 32'h10E, 32'd20, 32'h118, 1'b0);
    finish_pkt("single", 0);

    // Entries 0 and 2 valid; base near the top of the address space wraps.
    write_job(2'd2, 1'b1, 32'h40, 32'd7, 32'h1FC);
    start_pkt(32'hFFFF_FFF0);
    serve("multi job0", 2, 32'hFFFF_FFFE, 32'd20, 32'h0000_0008, 1'b0);
    serve("multi job2", 4, 32'h0000_0030, 32'd7, 32'h0000_01EC, 1'b0);
    finish_pkt("multi", 0);

    // Config write and pkt_start during WAIT are both dropped.
    write_job(2'd2, 1'b0, 32'h0, 32'd0, 32'h0);
    start_pkt(32'h500);
    serve("inject", 3, 32'h50E, 32'd20, 32'h518, 1'b1);
    finish_pkt("inject", 0);
    start_pkt(32'h200);
    serve("after inject", 2, 32'h20E, 32'd20, 32'h218, 1'b0);
    finish_pkt("after inject", 0);

    // Reset while waiting on the engine aborts without a done pulse.
    start_pkt(32'h300);
    for (int k = 0; k < 10 && start_o !== 1'b1; k++) cyc();
    cyc();
    cksum_ready_i = 1'b0;
    cyc();
    cyc();
    check("pre-abort start_o", start_o, 1'b1);
    rst = 1'b1;
    cyc();
    check("abort start_o", start_o, 1'b0);
    check("abort busy_o", busy_o, 1'b0);
    check("abort done_o", done_o, 1'b0);
    check("abort field_start_o", field_start_o, 32'h0);
    check("abort dst_field_start_o", dst_field_start_o, 32'h0);
    rst = 1'b0;
    cksum_ready_i = 1'b1;
    cyc();
    check("post-abort done_o", done_o, 1'b0);

    // Table write and pkt_start in the same cycle: new packet sees the new entry.
    set_cfg(2'd3, 1'b1, 32'h4, 32'd1, 32'h8);
    pkt_start_i = 1'b1;
    pkt_base_i  = 32'h1000;
    cyc();
    cfg_we_i    = 1'b0;
    pkt_start_i = 1'b0;
    serve("same-cycle", 2, 32'h1004, 32'd1, 32'h1008, 1'b0);
    finish_pkt("same-cycle", 0);

`ifdef CKSUM_SCHED_TIMEOUT_EN
    // Engine never answers: start drops on the 16th WAIT edge (17 edges after
    // start is first seen, counting the ISSUE edge), err_o sticks.
    start_pkt(32'h2000);
    for (int k = 0; k < 10 && start_o !== 1'b1; k++) cyc();
    check("timeout start rise", start_o, 1'b1);
    cksum_ready_i = 1'b0;
    begin
      int n = 0;
      while (start_o === 1'b1 && n < 40) begin
        cyc();
        n++;
      end
      check("timeout start fall cycle", n, 17);
    end
    check("timeout err_o set", err_o, 1'b1);
    finish_pkt("timeout", 0);
    check("timeout err_o sticky", err_o, 1'b1);
    cksum_ready_i = 1'b1;
`else
    check("err_o tied low", err_o, 1'b0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
